// File: rtl/hamming74_pkg.sv
// Hamming(7,4) shared definitions.
// Codeword bit i holds Hamming position i+1: {d4,d3,d2,p3,d1,p2,p1} from bit 6 down.
// Functions: encode (data -> code), syndrome, correct (single-bit flip), extract.
package hamming74_pkg;
  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  // {s3,s2,s1}; a nonzero value names the erroneous position directly.
  function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] c);
    logic s1, s2, s3;
    s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s3 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s3, s2, s1};
  endfunction

  // Flip position syn (bit syn-1); syn == 0 leaves the word untouched.
  function automatic logic [CODE_W-1:0] correct(input logic [CODE_W-1:0] c,
                                                input logic [SYN_W-1:0]  syn);
    logic [CODE_W-1:0] r;
    r = c;
    for (int i = 0; i < CODE_W; i++)
      if (syn == SYN_W'(i + 1)) r[i] = ~r[i];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction
endpackage

// File: rtl/hamming74_decoder.sv
// Hamming(7,4) receive decoder: 2-stage valid/ready pipeline with backpressure.
// S1 registers the codeword and its syndrome; S2 corrects, extracts data and
// presents it on the output. err_cnt saturates and counts errored outputs.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake, in_code = 7-bit codeword
//   out_valid/out_ready output handshake
//   out_data            corrected {d4,d3,d2,d1}
//   out_syndrome        0 = clean, else corrected position
//   out_err             out_syndrome != 0
//   err_cnt, cnt_clr    saturating corrected-word count, sync clear (priority)
module hamming74_decoder
  import hamming74_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic [2:0]        out_syndrome,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              cnt_clr
);

  logic                s1_valid_q;
  logic [CODE_W-1:0]   s1_code_q;
  logic [SYN_W-1:0]    s1_syn_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [SYN_W-1:0]    out_syn_q;
  logic                out_err_q;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                s2_adv, out_hs;

  assign s2_adv   = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign out_hs   = out_valid_q & out_ready;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr)
      err_cnt_d = '0;
    else if (out_hs && out_err_q && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_syn_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      // When S1 can load, it either takes a new word or empties (its old
      // content, if any, advances into S2 on this same edge).
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_code_q <= in_code;
          s1_syn_q  <= syndrome(in_code);
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= extract(correct(s1_code_q, s1_syn_q));
          out_syn_q  <= s1_syn_q;
          out_err_q  <= |s1_syn_q;
        end
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_syndrome = out_syn_q;
  assign out_err      = out_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: doc/hamming74_decoder.md
Name: hamming74_decoder

Overview:
- Receive side of the team's Hamming(7,4) link. Pairs with the existing 4-bit to 7-bit `codificador`.
- Accepts 7-bit codewords over a valid/ready stream and computes the 3-bit syndrome.
- Corrects any single-bit error and delivers the 4-bit data word through a 2-stage pipeline with backpressure.
- Keeps a saturating count of corrected words so the board display or other logic can read it.

Parameters:
- CNT_W, 8, width of the corrected-error counter (legal range 2..16).

Ports:
- clk  input  1  single system clock; all flops on the rising edge.
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clk.
- in_valid  input  1  in_code holds a codeword.
- in_ready  output  1  decoder accepts in_code this cycle.
- in_code  input  7  codeword; bit i = Hamming position i+1 (p1 p2 d1 p3 d2 d3 d4 from bit 0 up).
- out_valid  output  1  out_data, out_syndrome and out_err are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  4  corrected data {d4,d3,d2,d1}.
- out_syndrome  output  3  syndrome {s3,s2,s1}; 0 = clean, 1..7 = corrected bit position.
- out_err  output  1  1 when out_syndrome != 0.
- err_cnt  output  CNT_W  count of corrected words.
- cnt_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - Both stage valids, out_valid, out_data, out_syndrome, out_err and err_cnt = 0.
  - in_ready = 1 combinationally once reset is deasserted.
- Encoding convention (the decoder must match it):
  - p1 = d1^d2^d4; p2 = d1^d3^d4; p3 = d2^d3^d4.
- Syndrome, computed on the codeword c[7:1]:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s3 = c4^c5^c6^c7
- Stage 1 (S1):
  - On an input handshake (in_valid & in_ready), register in_code and the syndrome; set s1_valid.
- Stage 2 (S2 / output):
  - When S1 advances, flip codeword bit (syndrome-1) if the syndrome is nonzero.
  - Register the extracted data {c7,c6,c5,c3}, the syndrome and err; set out_valid.
- Pipeline control:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = ~s1_valid | s2_adv.
  - Full throughput: one word per cycle while out_ready = 1.
- Latency: exactly 2 cycles from input handshake to out_valid with no stall.
- Stall rules:
  - While out_valid & ~out_ready, all output signals hold stable.
  - With both stages full and stalled, in_ready = 0.
  - Nothing is ever dropped or duplicated.
- Bubbles:
  - out_valid drops to 0 after an output handshake when S1 is empty.
  - s1_valid drops after an advance with no new input.
- Parity-bit errors (syndrome 1, 2 or 4): out_data is unchanged, out_err = 1.
- Double-bit errors: not detectable in (7,4). The decoder miscorrects and reports a nonzero syndrome; this is accepted behaviour.
- Counter:
  - err_cnt increments by 1 on each output handshake with out_err = 1.
  - It saturates at all-ones with no wrap.
  - cnt_clr has priority: a simultaneous clear and increment yields 0.
- Reset mid-stream: in-flight words are discarded. After reset the first output is the first word accepted after rst_n rises.

Decomposition:
- Shared package hamming74_pkg holds:
  - constants CODE_W = 7 and DATA_W = 4;
  - function syndrome(code) returning 3 bits;
  - function correct(code, syn) returning a 7-bit code;
  - function extract(code) returning 4 bits.
- The package must also expose encode(data) for the bench and for a later `codificador` refactor.
- No sub-module: the pipeline and counter live in one module. The combinational work lives in the package functions.

Test Plan:
- Clean words, streaming: 0000→7'b0000000, 0001→7'b0000111, 1011→7'b1010101, 1111→7'b1111111.
  - Required response: out_data equals the original data, syndrome 0, err 0, outputs 2 cycles later, one per cycle, err_cnt stays 0.
- Single data-bit error: 7'b1000101 (1011 with position 5 flipped).
  - Required response: out_data = 4'b1011, out_syndrome = 3'd5, out_err = 1, err_cnt = 1.
- Parity-bit error: 7'b0000110 (0001 with position 1 flipped).
  - Required response: out_data = 4'b0001, syndrome = 1.
- Exhaustive sweep: all 16 data values × 8 flip positions (none, 1..7) from package encode().
  - Required response: always correct data; syndrome equals the flip position.
- Backpressure: stream 1011, 0001, 1111 while holding out_ready = 0 for 3 cycles.
  - Required response: in_ready = 0 once 2 words are buffered; outputs stay stable; all 3 words emerge in order after release.
- Counter and reset:
  - Force CNT_W = 2 and send 5 errored words: err_cnt = 3 (saturated).
  - Assert cnt_clr together with an errored output handshake: err_cnt = 0.
  - Pulse rst_n low with words in flight: out_valid = 0 immediately; no stale word appears afterwards.
